// File: rtl/multiword_add_seq.sv
// -----------------------------------------------------------------------------
// multiword_add_seq
//    Sequenced multi-precision adder/subtractor for W = N*K bit operands.
//    One N-bit add slice is reused over K cycles, least-significant chunk
//    first, with the inter-chunk carry held in a register.
//
// Parameters
//    N     chunk width in bits (N >= 1)
//    K     number of chunks (K >= 1); W = N*K
//
// Ports
//    clk    in   rising-edge clock
//    reset  in   asynchronous, active-high reset
//    start  in   request, sampled only while idle
//    sub    in   0 = a+b, 1 = a-b; latched with the operands
//    a, b   in   W-bit operands, latched on an accepted start
//    busy   out  high while an operation is running or completing
//    done   out  one-cycle pulse, result valid
//    s      out  W-bit sum/difference, held until the next accepted start
//    cout   out  final carry out (subtract: 1 = no borrow, a >= b unsigned)
//    ovf    out  signed two's-complement overflow of the full W-bit operation
// -----------------------------------------------------------------------------
module multiword_add_seq #(
   parameter int N = 4,
   parameter int K = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             sub,
   input  logic [N*K-1:0]   a,
   input  logic [N*K-1:0]   b,
   output logic             busy,
   output logic             done,
   output logic [N*K-1:0]   s,
   output logic             cout,
   output logic             ovf
);

   localparam int W  = N * K;
   localparam int IW = (K > 1) ? $clog2(K) : 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t          state;
   logic [IW-1:0]   idx;
   logic            carry;
   logic [W-1:0]    a_r;
   logic [W-1:0]    b_r;

   logic [N-1:0]    a_chunk;
   logic [N-1:0]    b_chunk;
   logic [N-1:0]    r;
   logic            c;
   logic            msb_cin;
   logic            last;
   logic [W-1:0]    s_next;

   // Chunk selection and the shared N+1 bit add slice.
   always_comb begin
      a_chunk = '0;
      b_chunk = '0;
      for (int unsigned i = 0; i < K; i++) begin
         if (idx == IW'(i)) begin
            a_chunk = a_r[i*N +: N];
            b_chunk = b_r[i*N +: N];
         end
      end

      {c, r} = {1'b0, a_chunk} + {1'b0, b_chunk} + {{N{1'b0}}, carry};

      // Carry into the top bit of the chunk recovered from its sum bit;
      // this also covers N = 1, where it is simply the incoming carry.
      msb_cin = a_chunk[N-1] ^ b_chunk[N-1] ^ r[N-1];

      last = (idx == IW'(K - 1));

      s_next = s;
      for (int unsigned i = 0; i < K; i++) begin
         if (idx == IW'(i)) begin
            s_next[i*N +: N] = r;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         idx   <= '0;
         carry <= 1'b0;
         a_r   <= '0;
         b_r   <= '0;
         s     <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
         done  <= 1'b0;
         busy  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  // Subtraction is A + ~B + 1: invert B now, seed carry with 1.
                  a_r   <= a;
                  b_r   <= sub ? ~b : b;
                  carry <= sub;
                  idx   <= '0;
                  s     <= '0;
                  cout  <= 1'b0;
                  ovf   <= 1'b0;
                  busy  <= 1'b1;
                  state <= RUN;
               end
            end

            RUN: begin
               s     <= s_next;
               carry <= c;
               if (last) begin
                  // Index returns to 0 so it never exceeds K-1.
                  idx   <= '0;
                  cout  <= c;
                  ovf   <= msb_cin ^ c;
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  idx   <= idx + IW'(1);
               end
            end

            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end

            default: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multiword_add_seq.sv
module tb_multiword_add_seq;

   localparam int N = 4;
   localparam int K = 4;
   localparam int W = N * K;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          sub;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          busy;
   logic          done;
   logic [W-1:0]  s;
   logic          cout;
   logic          ovf;

   multiword_add_seq #(.N(N), .K(K)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .sub   (sub),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .s     (s),
      .cout  (cout),
      .ovf   (ovf)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [W-1:0] s;
      logic         cout;
      logic         ovf;
   } exp_t;

   exp_t sb[$];
   int   n_cmp  = 0;
   int   n_fail = 0;
   logic prev_done = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: plain integer arithmetic on the whole W-bit values.
   function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic op);
      longint unsigned full;
      longint          sx, sy, r;
      exp_t            e;
      full = op ? (longint'(x) + (longint'(1) << W) - longint'(y))
                : (longint'(x) + longint'(y));
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      r  = op ? (sx - sy) : (sx + sy);
      e.s    = W'(full);
      e.cout = full >= (longint'(1) << W);
      e.ovf  = (r > ((longint'(1) << (W-1)) - 1)) || (r < -(longint'(1) << (W-1)));
      return e;
   endfunction

   function automatic exp_t mk(input logic [W-1:0] es, input logic ec, input logic eo);
      exp_t e;
      e.s = es; e.cout = ec; e.ovf = eo;
      return e;
   endfunction

   // Monitor: pops the scoreboard on every done pulse.
   always @(negedge clk) begin
      if (done) begin
         check("done_back_to_back", {31'd0, prev_done}, 32'd0);
         check("sb_nonempty_at_done", (sb.size() == 0) ? 32'd0 : 32'd1, 32'd1);
         if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            check("result_s",    {16'd0, s},     {16'd0, e.s});
            check("result_cout", {31'd0, cout},  {31'd0, e.cout});
            check("result_ovf",  {31'd0, ovf},   {31'd0, e.ovf});
         end
      end
      prev_done = done;
   end

   task automatic wait_idle();
      int t;
      t = 0;
      @(negedge clk);
      while (busy && t < 50) begin
         @(negedge clk);
         t++;
      end
      check("idle_timeout", {31'd0, busy}, 32'd0);
   endtask

   task automatic wait_drain();
      int t;
      t = 0;
      while (sb.size() != 0 && t < 100) begin
         @(negedge clk);
         t++;
      end
      check("drain_timeout", sb.size(), 32'd0);
   endtask

   // Issue one operation; returns 1 time unit after the accepting edge.
   task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic op, input exp_t e);
      wait_idle();
      start = 1'b1; a = x; b = y; sub = op;
      @(posedge clk);
      sb.push_back(e);
      #1;
      start = 1'b0;
      a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
      #12;
      check("rst_s",    {16'd0, s},    32'd0);
      check("rst_cout", {31'd0, cout}, 32'd0);
      check("rst_ovf",  {31'd0, ovf},  32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      reset = 1'b0;

      // Timing of the first operation.
      issue(16'h00FF, 16'h0001, 1'b0, mk(16'h0100, 1'b0, 1'b0));
      check("busy_after_E0", {31'd0, busy}, 32'd1);
      for (int cyc = 1; cyc <= 5; cyc++) begin
         @(posedge clk);
         #1;
         check($sformatf("busy_after_E%0d", cyc), {31'd0, busy}, (cyc <= 4) ? 32'd1 : 32'd0);
         check($sformatf("done_after_E%0d", cyc), {31'd0, done}, (cyc == 4) ? 32'd1 : 32'd0);
      end
      repeat (3) @(posedge clk);
      #1;
      check("hold_s",    {16'd0, s},    32'h0100);
      check("hold_cout", {31'd0, cout}, 32'd0);
      check("hold_ovf",  {31'd0, ovf},  32'd0);

      // Boundary cases with fixed expectations.
      issue(16'hFFFF, 16'h0001, 1'b0, mk(16'h0000, 1'b1, 1'b0));
      issue(16'h7FFF, 16'h0001, 1'b0, mk(16'h8000, 1'b0, 1'b1));
      issue(16'h0005, 16'h0007, 1'b1, mk(16'hFFFE, 1'b0, 1'b0));
      issue(16'h8000, 16'h0001, 1'b1, mk(16'h7FFF, 1'b1, 1'b1));
      wait_drain();

      // Asynchronous reset in the middle of an add.
      issue(16'h0F0F, 16'h0101, 1'b0, model(16'h0F0F, 16'h0101, 1'b0));
      @(posedge clk);
      @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      check("midrst_s",    {16'd0, s},    32'd0);
      check("midrst_cout", {31'd0, cout}, 32'd0);
      check("midrst_ovf",  {31'd0, ovf},  32'd0);
      check("midrst_done", {31'd0, done}, 32'd0);
      check("midrst_busy", {31'd0, busy}, 32'd0);
      sb.delete();
      repeat (3) @(posedge clk);
      #2;
      reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("no_done_after_reset", {31'd0, done}, 32'd0);
      end
      issue(16'h1234, 16'h1111, 1'b0, mk(16'h2345, 1'b0, 1'b0));
      wait_drain();

      // start held high, operands changing every cycle: accepts every K+2 edges.
      wait_idle();
      start = 1'b1;
      a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
      for (int e = 0; e < 6 * (K + 2); e++) begin
         @(posedge clk);
         if (e % (K + 2) == 0) sb.push_back(model(a, b, sub));
         #1;
         a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
      end
      start = 1'b0;
      wait_drain();

      // Randomized operations against the reference model.
      for (int i = 0; i < 40; i++) begin
         logic [W-1:0] x, y;
         logic         op;
         x  = W'($urandom);
         y  = W'($urandom);
         op = 1'($urandom);
         if (i % 8 == 0) y = x;
         issue(x, y, op, model(x, y, op));
      end
      wait_drain();
      repeat (4) @(negedge clk);
      check("sb_empty_end", sb.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/multiword_add_seq.md
Name: multiword_add_seq

Overview:
- Sequenced multi-precision adder/subtractor for W = N*K bit operands.
- Reuses one N-bit add slice (plus carry) over K cycles, least-significant chunk first, holding the carry in a register between chunks.
- Sits between a requesting controller (start/done handshake) and the wide result consumer, so wide arithmetic costs only a narrow adder.

Parameters:
- N, 4, chunk width in bits (N >= 1).
- K, 4, number of chunks (K >= 1); operand/result width W = N*K.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- sub  input  1  0 = a+b, 1 = a-b; latched with operands
- a  input  W  operand A; latched on accepted start
- b  input  W  operand B; latched on accepted start
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse, result valid
- s  output  W  sum/difference; holds until next accepted start
- cout  output  1  final carry out (subtract: 1 = no borrow, a >= b unsigned)
- ovf  output  1  signed two's-complement overflow of full W-bit op

Behaviour:
- Reset (async, any state) forces:
  - state = IDLE; chunk index, carry and operand registers = 0.
  - s = 0, cout = 0, ovf = 0, done = 0, busy = 0.
  - Reset mid-operation abandons the operation; no done is produced for it.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On an edge with start = 1: latch A <= a; B <= (sub ? ~b : b); carry <= sub; idx <= 0; s <= 0; cout <= 0; ovf <= 0; go to RUN.
  - start = 0: stay in IDLE.
- RUN, each edge:
  - {c, r} = A[idx*N +: N] + B[idx*N +: N] + carry, computed at N+1 bits.
  - s[idx*N +: N] <= r; carry <= c; idx <= idx + 1.
  - When idx == K-1: cout <= c; ovf <= (carry into bit W-1) XOR c; go to DONE.
- DONE:
  - done = 1 for exactly this cycle (Moore output); next edge goes to IDLE.
- Timing:
  - start sampled at edge E0.
  - Chunks are written at edges E1..EK.
  - done is high in the cycle between EK and EK+1.
  - busy is high from E0 through EK+1; IDLE is re-entered at EK+1.
  - The earliest next start is sampled at EK+2, so the minimum issue interval is K+2 cycles.
- start in RUN or DONE is ignored; it is not queued.
- a, b and sub may change freely after the accepting edge without effect.
- Intermediate s chunks are visible during RUN; s is valid only when done = 1 and afterwards, until the next accepted start.
- Width rules:
  - Chunk arithmetic is unsigned, N+1 bits.
  - Result wraps modulo 2^W.
  - Subtract is A + ~B + 1.
  - ovf = carry into MSB XOR carry out of MSB; the carry into the MSB comes from the last chunk's internal bit N-1 carry.
- K = 1: RUN lasts one cycle; done appears in the cycle after E1.
- idx is ceil(log2(K)) bits, minimum 1; it never exceeds K-1.

Test Plan:
All cases use N=4, K=4 (W=16).
- add a=16'h00FF, b=16'h0001, start pulsed at E0 -> busy high from E0; done only between E4 and E5; s=16'h0100, cout=0, ovf=0; outputs hold after done.
- add a=16'hFFFF, b=16'h0001 -> s=16'h0000, cout=1, ovf=0.
- add a=16'h7FFF, b=16'h0001 -> s=16'h8000, cout=0, ovf=1.
- sub a=16'h0005, b=16'h0007 -> s=16'hFFFE, cout=0, ovf=0; then sub a=16'h8000, b=16'h0001 -> s=16'h7FFF, cout=1, ovf=1.
- reset asserted asynchronously between E2 and E3 of an add -> s, cout, ovf, done, busy go 0 immediately without a clock edge; no done pulse follows; after release, add a=16'h1234, b=16'h1111 -> s=16'h2345.
- start held high continuously, a/b changed every cycle -> one operation every 6 cycles using the operands present at each IDLE-sampling edge; no done pulses back-to-back; start pulses in RUN/DONE are ignored.
